// File: rtl/jstack_ctl.sv
// JVM stack RAM sequencer: runs engine stack micro-ops and MCU random accesses
// on one single-ported RAM, owning the stack pointer (jsp) and frame pointer (jframe).
module jstack_ctl #(
    parameter int AW      = 10,
    parameter int RAM_LAT = 1
) (
    input  logic          sysclk,
    input  logic          sysreset_n,
    input  logic          e_valid,
    output logic          e_ready,
    input  logic [2:0]    e_cmd,
    input  logic [AW-1:0] e_ofs,
    input  logic [15:0]   e_wdata,
    output logic          e_done,
    output logic [15:0]   e_rdata,
    input  logic          m_req,
    input  logic          m_we,
    input  logic [AW-1:0] m_addr,
    input  logic [15:0]   m_wdata,
    output logic          m_ack,
    output logic [15:0]   m_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_wdata,
    output logic          ram_wren,
    input  logic [15:0]   ram_q,
    output logic [AW-1:0] jsp,
    output logic [AW-1:0] jframe,
    output logic          err,
    input  logic          err_clr,
    output logic [2:0]    dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DUPWR = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] C_PUSH  = 3'd0;
    localparam logic [2:0] C_POP   = 3'd1;
    localparam logic [2:0] C_PEEK  = 3'd2;
    localparam logic [2:0] C_DUP   = 3'd3;
    localparam logic [2:0] C_LOAD  = 3'd4;
    localparam logic [2:0] C_STORE = 3'd5;
    localparam logic [2:0] C_SETSP = 3'd6;
    localparam logic [2:0] C_SETFP = 3'd7;

    localparam logic [AW-1:0] JSP_MAX = '1;
    localparam logic [AW-1:0] ONE     = 1;
    localparam logic [1:0]    WAIT_LD = 2'(RAM_LAT - 1);

    logic [2:0]    state;
    logic [2:0]    cmd_q;
    logic [AW-1:0] val_q;
    logic          mcu_q;
    logic          mwe_q;
    logic          flt_q;
    logic          last_m;
    logic [1:0]    wcnt;

    logic          grant_e;
    logic          grant_m;
    logic          fault_e;
    logic          touch_e;
    logic          write_e;
    logic [AW-1:0] jsp_m1;
    logic [AW-1:0] addr_e;

    // Handshake: an engine command transfers on a cycle with e_valid && e_ready
    // (e_ready is high only in IDLE); m_req is a level held until the m_ack pulse.
    assign e_ready   = (state == S_IDLE);
    assign e_done    = (state == S_DONE) && !mcu_q;
    assign m_ack     = (state == S_DONE) && mcu_q;
    assign dbg_state = state;
    assign jsp_m1    = jsp - ONE;

    // On a tie the side that did not win last time is granted.
    assign grant_e = (state == S_IDLE) && e_valid && (!m_req || last_m);
    assign grant_m = (state == S_IDLE) && m_req && (!e_valid || !last_m);

    always_comb begin
        fault_e = 1'b0;
        touch_e = 1'b1;
        write_e = 1'b0;
        addr_e  = jsp;
        case (e_cmd)
            C_PUSH:  begin fault_e = (jsp == JSP_MAX); write_e = 1'b1; end
            C_POP:   begin fault_e = (jsp == '0); addr_e = jsp_m1; end
            C_PEEK:  begin fault_e = (e_ofs >= jsp); addr_e = jsp_m1 - e_ofs; end
            C_DUP:   begin fault_e = (jsp == '0) || (jsp == JSP_MAX); addr_e = jsp_m1; end
            C_LOAD:  addr_e = jframe + e_ofs;
            C_STORE: begin addr_e = jframe + e_ofs; write_e = 1'b1; end
            default: touch_e = 1'b0;
        endcase
    end

    // RAM address/data are registered on entry to ISSUE (or DUPWR) so they are
    // presented during that cycle; ram_wren is a single-cycle pulse.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state     <= S_IDLE;
            cmd_q     <= C_PUSH;
            val_q     <= '0;
            mcu_q     <= 1'b0;
            mwe_q     <= 1'b0;
            flt_q     <= 1'b0;
            last_m    <= 1'b1;
            wcnt      <= '0;
            jsp       <= '0;
            jframe    <= '0;
            err       <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
            e_rdata   <= '0;
            m_rdata   <= '0;
        end else begin
            ram_wren <= 1'b0;
            if (err_clr) err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_e) begin
                        last_m <= 1'b0;
                        mcu_q  <= 1'b0;
                        cmd_q  <= e_cmd;
                        val_q  <= e_wdata[AW-1:0];
                        flt_q  <= fault_e;
                        if (!fault_e && touch_e) ram_addr <= addr_e;
                        if (!fault_e && write_e) begin
                            ram_wdata <= e_wdata;
                            ram_wren  <= 1'b1;
                        end
                        state <= S_ISSUE;
                    end else if (grant_m) begin
                        last_m   <= 1'b1;
                        mcu_q    <= 1'b1;
                        mwe_q    <= m_we;
                        flt_q    <= 1'b0;
                        ram_addr <= m_addr;
                        if (m_we) begin
                            ram_wdata <= m_wdata;
                            ram_wren  <= 1'b1;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wcnt <= WAIT_LD;
                    if (mcu_q) begin
                        state <= mwe_q ? S_DONE : S_WAIT;
                    end else if (flt_q) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        case (cmd_q)
                            C_PUSH:  begin jsp <= jsp + ONE; state <= S_DONE; end
                            C_STORE: state <= S_DONE;
                            C_SETSP: begin jsp <= val_q; state <= S_DONE; end
                            C_SETFP: begin jframe <= val_q; state <= S_DONE; end
                            C_POP:   begin jsp <= jsp_m1; state <= S_WAIT; end
                            default: state <= S_WAIT;
                        endcase
                    end
                end
                S_WAIT: begin
                    if (wcnt == '0) begin
                        if (mcu_q) m_rdata <= ram_q;
                        else e_rdata <= ram_q;
                        if (!mcu_q && cmd_q == C_DUP) begin
                            ram_addr  <= jsp;
                            ram_wdata <= ram_q;
                            ram_wren  <= 1'b1;
                            state     <= S_DUPWR;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        wcnt <= wcnt - 2'd1;
                    end
                end
                S_DUPWR: begin
                    jsp   <= jsp + ONE;
                    state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jstack_ctl.sv
// Bench for jstack_ctl: table of engine ops with expected results, plus hand-written
// sequences for error clearing, MCU access, reset abort and round-robin arbitration.
module tb_jstack_ctl;

    localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, PEEK = 3'd2, DUP = 3'd3;
    localparam logic [2:0] LOAD = 3'd4, STORE = 3'd5, SETSP = 3'd6, SETFP = 3'd7;

    logic        sysclk = 1'b0;
    logic        sysreset_n;
    logic        e_valid, e_ready, e_done;
    logic [2:0]  e_cmd;
    logic [9:0]  e_ofs;
    logic [15:0] e_wdata, e_rdata;
    logic        m_req, m_we, m_ack;
    logic [9:0]  m_addr;
    logic [15:0] m_wdata, m_rdata;
    logic [9:0]  ram_addr;
    logic [15:0] ram_wdata, ram_q;
    logic        ram_wren;
    logic [9:0]  jsp, jframe;
    logic        err, err_clr;
    logic [2:0]  dbg_state;

    jstack_ctl #(.AW(10), .RAM_LAT(1)) dut (
        .sysclk(sysclk), .sysreset_n(sysreset_n),
        .e_valid(e_valid), .e_ready(e_ready), .e_cmd(e_cmd), .e_ofs(e_ofs),
        .e_wdata(e_wdata), .e_done(e_done), .e_rdata(e_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
        .jsp(jsp), .jframe(jframe), .err(err), .err_clr(err_clr), .dbg_state(dbg_state)
    );

    always #5 sysclk = ~sysclk;

    // Single-port RAM with registered address, one cycle read latency.
    logic [15:0] mem [0:1023];
    logic [9:0]  addr_r;
    always @(posedge sysclk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        addr_r <= ram_addr;
    end
    assign ram_q = mem[addr_r];

    typedef struct {
        logic [2:0]  cmd;
        logic [9:0]  ofs;
        logic [15:0] wd;
        bit          rd;
        logic [15:0] rdata;
        logic [9:0]  jsp;
        logic [9:0]  jfr;
        bit          err;
        int          lat;
        int          wr;
        int          maddr;
        logic [15:0] mdata;
    } vec_t;

    vec_t        tbl [21];
    logic [15:0] exp_q[$];
    logic [15:0] m_exp_q[$];
    int          n_checks = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic eng_op(input logic [2:0] cmd, input logic [9:0] ofs, input logic [15:0] wd,
                          input bit rd, output int lat, output int wr);
        int g = 0;
        lat = -1;
        wr  = 0;
        while (!e_ready && g < 20) begin @(negedge sysclk); g++; end
        e_cmd = cmd; e_ofs = ofs; e_wdata = wd; e_valid = 1'b1;
        @(negedge sysclk);
        e_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (ram_wren) wr++;
            if (e_done) begin lat = n; break; end
            @(negedge sysclk);
        end
        if (lat < 0) chk("e_done_timeout", e_done, 1);
        else if (rd) begin
            if (exp_q.size() == 0) chk("exp_q_empty", 0, 1);
            else chk("e_rdata", e_rdata, exp_q.pop_front());
        end
    endtask

    task automatic m_op(input bit we, input logic [9:0] a, input logic [15:0] wd);
        m_we = we; m_addr = a; m_wdata = wd; m_req = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(negedge sysclk);
            if (m_ack) break;
        end
        chk("m_ack", m_ack, 1);
        if (m_ack && !we) chk("m_rdata", m_rdata, m_exp_q.pop_front());
        m_req = 1'b0;
    endtask

    initial begin
        int lat, wr, ev, overlap, dones;
        logic [3:0] order;

        tbl[0]  = '{PUSH,  10'd0, 16'h1111, 0, 16'h0000, 10'd1,    10'd0,   0, 2, 1, -1, 16'h0};
        tbl[1]  = '{PUSH,  10'd0, 16'h2222, 0, 16'h0000, 10'd2,    10'd0,   0, 2, 1, -1, 16'h0};
        tbl[2]  = '{POP,   10'd0, 16'h0000, 1, 16'h2222, 10'd1,    10'd0,   0, 3, 0,  1, 16'h2222};
        tbl[3]  = '{SETFP, 10'd0, 16'h0005, 0, 16'h0000, 10'd1,    10'd5,   0, 2, 0, -1, 16'h0};
        tbl[4]  = '{STORE, 10'd2, 16'hBEEF, 0, 16'h0000, 10'd1,    10'd5,   0, 2, 1,  7, 16'hBEEF};
        tbl[5]  = '{LOAD,  10'd2, 16'h0000, 1, 16'hBEEF, 10'd1,    10'd5,   0, 3, 0, -1, 16'h0};
        tbl[6]  = '{PUSH,  10'd0, 16'h0033, 0, 16'h0000, 10'd2,    10'd5,   0, 2, 1, -1, 16'h0};
        tbl[7]  = '{PUSH,  10'd0, 16'h00AA, 0, 16'h0000, 10'd3,    10'd5,   0, 2, 1,  2, 16'h00AA};
        tbl[8]  = '{DUP,   10'd0, 16'h0000, 1, 16'h00AA, 10'd4,    10'd5,   0, 4, 1,  3, 16'h00AA};
        tbl[9]  = '{PEEK,  10'd1, 16'h0000, 1, 16'h00AA, 10'd4,    10'd5,   0, 3, 0, -1, 16'h0};
        tbl[10] = '{PEEK,  10'd3, 16'h0000, 1, 16'h1111, 10'd4,    10'd5,   0, 3, 0, -1, 16'h0};
        tbl[11] = '{PEEK,  10'd4, 16'h0000, 1, 16'h1111, 10'd4,    10'd5,   1, 2, 0, -1, 16'h0};
        tbl[12] = '{SETSP, 10'd0, 16'h0000, 0, 16'h0000, 10'd0,    10'd5,   1, 2, 0, -1, 16'h0};
        tbl[13] = '{POP,   10'd0, 16'h0000, 1, 16'h1111, 10'd0,    10'd5,   1, 2, 0, -1, 16'h0};
        tbl[14] = '{SETSP, 10'd0, 16'h03FF, 0, 16'h0000, 10'd1023, 10'd5,   1, 2, 0, -1, 16'h0};
        tbl[15] = '{PUSH,  10'd0, 16'h5555, 0, 16'h0000, 10'd1023, 10'd5,   1, 2, 0, -1, 16'h0};
        tbl[16] = '{DUP,   10'd0, 16'h0000, 1, 16'h1111, 10'd1023, 10'd5,   1, 2, 0, -1, 16'h0};
        tbl[17] = '{SETFP, 10'd0, 16'h03FE, 0, 16'h0000, 10'd1023, 10'h3FE, 1, 2, 0, -1, 16'h0};
        tbl[18] = '{STORE, 10'd3, 16'h7777, 0, 16'h0000, 10'd1023, 10'h3FE, 1, 2, 1,  1, 16'h7777};
        tbl[19] = '{LOAD,  10'd3, 16'h0000, 1, 16'h7777, 10'd1023, 10'h3FE, 1, 3, 0, -1, 16'h0};
        tbl[20] = '{SETSP, 10'd0, 16'hF802, 0, 16'h0000, 10'd2,    10'h3FE, 1, 2, 0, -1, 16'h0};

        sysreset_n = 1'b0;
        e_valid = 1'b0; e_cmd = 3'd0; e_ofs = '0; e_wdata = '0;
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; err_clr = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("rst_jsp", jsp, 0);
        chk("rst_jframe", jframe, 0);
        chk("rst_err", err, 0);
        chk("rst_e_done", e_done, 0);
        chk("rst_m_ack", m_ack, 0);
        chk("rst_ram_wren", ram_wren, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_e_rdata", e_rdata, 0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_e_ready", e_ready, 1);
        sysreset_n = 1'b1;
        @(negedge sysclk);

        foreach (tbl[i]) begin
            if (tbl[i].rd) exp_q.push_back(tbl[i].rdata);
            eng_op(tbl[i].cmd, tbl[i].ofs, tbl[i].wd, tbl[i].rd, lat, wr);
            chk($sformatf("lat[%0d]", i), lat, tbl[i].lat);
            chk($sformatf("wren[%0d]", i), wr, tbl[i].wr);
            chk($sformatf("jsp[%0d]", i), jsp, tbl[i].jsp);
            chk($sformatf("jframe[%0d]", i), jframe, tbl[i].jfr);
            chk($sformatf("err[%0d]", i), err, tbl[i].err);
            if (tbl[i].maddr >= 0)
                chk($sformatf("mem[%0d]", i), mem[tbl[i].maddr[9:0]], tbl[i].mdata);
        end

        // err clear, then set-wins-over-clear on an overflowing PUSH
        err_clr = 1'b1; @(negedge sysclk); err_clr = 1'b0;
        chk("err_clr", err, 0);
        eng_op(SETSP, 10'd0, 16'h03FF, 0, lat, wr);
        err_clr = 1'b1;
        eng_op(PUSH, 10'd0, 16'h5555, 0, lat, wr);
        chk("err_set_wins", err, 1);
        chk("ovf_jsp", jsp, 1023);
        chk("ovf_wren", wr, 0);
        err_clr = 1'b0;
        @(negedge sysclk);
        err_clr = 1'b1; @(negedge sysclk); err_clr = 1'b0;
        chk("err_clr2", err, 0);
        eng_op(SETSP, 10'd0, 16'h0002, 0, lat, wr);

        // MCU write then read back; pointers untouched
        m_op(1'b1, 10'd20, 16'hCAFE);
        chk("m_wr_mem", mem[20], 16'hCAFE);
        chk("m_wr_jsp", jsp, 2);
        chk("m_wr_jframe", jframe, 10'h3FE);
        @(negedge sysclk);
        m_exp_q.push_back(16'hCAFE);
        m_op(1'b0, 10'd20, 16'h0000);
        @(negedge sysclk);

        // Reset asserted while a POP waits on the RAM
        chk("pre_pop_ready", e_ready, 1);
        e_cmd = POP; e_ofs = '0; e_valid = 1'b1;
        @(negedge sysclk); e_valid = 1'b0;
        @(negedge sysclk);
        chk("pop_in_wait", dbg_state, 2);
        sysreset_n = 1'b0;
        #1;
        chk("abort_jsp", jsp, 0);
        chk("abort_wren", ram_wren, 0);
        chk("abort_done", e_done, 0);
        @(negedge sysclk);
        sysreset_n = 1'b1;
        chk("abort_ready", e_ready, 1);
        dones = 0;
        repeat (5) begin @(negedge sysclk); if (e_done) dones++; end
        chk("abort_no_done", dones, 0);

        // Both sides requesting continuously: E,M,E,M after reset
        exp_q.push_back(16'hBEEF); exp_q.push_back(16'hBEEF);
        m_exp_q.push_back(16'h7777); m_exp_q.push_back(16'h7777);
        e_cmd = LOAD; e_ofs = 10'd7; e_valid = 1'b1;
        m_we = 1'b0; m_addr = 10'd1; m_req = 1'b1;
        ev = 0; overlap = 0; order = '0;
        for (int n = 0; n < 80 && ev < 4; n++) begin
            @(negedge sysclk);
            if (e_done && m_ack) overlap++;
            if (e_done && ev < 4) begin
                order[ev] = 1'b0; ev++;
                chk("arb_e_rdata", e_rdata, exp_q.pop_front());
            end
            if (m_ack && ev < 4) begin
                order[ev] = 1'b1; ev++;
                chk("arb_m_rdata", m_rdata, m_exp_q.pop_front());
            end
            if (ev == 4) begin e_valid = 1'b0; m_req = 1'b0; end
        end
        e_valid = 1'b0; m_req = 1'b0;
        chk("arb_grants", ev, 4);
        chk("arb_order", order, 4'b1010);
        chk("arb_overlap", overlap, 0);
        chk("arb_jsp", jsp, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/jstack_ctl.md
Name: jstack_ctl

Overview:
- Sequencer and arbiter for the single-ported JVM stack RAM (M9K, registered address) that holds operands, locals and call frames.
- Owns the JVM stack pointer (jsp) and frame pointer (jframe).
- Executes stack micro-ops (push, pop, peek, dup, local load/store, pointer set) for the bytecode engine, and shares the RAM with MCU random-access requests via round-robin.
- Sits between the Synapse316 register-file decode and the jstack RAM macro.

Parameters:
AW, 10, RAM address width; depth 2^AW words; jsp/jframe width.
RAM_LAT, 1, cycles from address presented to ram_q valid (1..3).

Ports:
sysclk  in  1  system clock.
sysreset_n  in  1  reset, asynchronous, active-low.
e_valid  in  1  engine command request.
e_ready  out  1  controller idle; command accepted when e_valid&&e_ready.
e_cmd  in  3  0 PUSH, 1 POP, 2 PEEK, 3 DUP, 4 LOAD, 5 STORE, 6 SETSP, 7 SETFP.
e_ofs  in  AW  offset (PEEK: below top; LOAD/STORE: from jframe).
e_wdata  in  16  PUSH/STORE data; SETSP/SETFP value (low AW bits).
e_done  out  1  one-cycle completion pulse.
e_rdata  out  16  POP/PEEK/DUP/LOAD result; held until next read-type done.
m_req  in  1  MCU random-access request, level, held until m_ack.
m_we  in  1  MCU write enable.
m_addr  in  AW  MCU address.
m_wdata  in  16  MCU write data.
m_ack  out  1  one-cycle completion pulse.
m_rdata  out  16  MCU read result, valid with m_ack, held after.
ram_addr  out  AW  RAM address.
ram_wdata  out  16  RAM write data.
ram_wren  out  1  RAM write enable.
ram_q  in  16  RAM read data.
jsp  out  AW  stack pointer; next free slot.
jframe  out  AW  frame pointer.
err  out  1  sticky over/underflow flag.
err_clr  in  1  clears err; a same-cycle set wins.

Behaviour:
- Reset (async, active-low): state IDLE; jsp=0, jframe=0, err=0, e_done=0, m_ack=0, ram_wren=0, ram_addr=0, ram_wdata=0, e_rdata=0, m_rdata=0, last_grant=MCU.
- Reset mid-operation aborts the operation. A write not yet clocked is not performed. No done/ack is issued.
- States: IDLE, ISSUE, WAIT, DUPWR, DONE.
- e_ready=1 only in IDLE. m_req is sampled only in IDLE.
- Arbitration in IDLE:
  - Single requester is granted.
  - If both request, grant the side that is not last_grant.
  - last_grant updates on each grant.
- Grant cycle (cycle 0): latch cmd/ofs/wdata (or MCU fields); go to ISSUE.
- ISSUE (cycle 1): drive ram_addr.
  - Write ops drive ram_wren=1 for exactly this cycle.
  - PUSH: addr=jsp, data=e_wdata; jsp<=jsp+1.
  - STORE: addr=(jframe+ofs) mod 2^AW.
  - MCU write: addr=m_addr.
  - SETSP/SETFP: load pointer, no RAM access.
  - Writes and SET* go to DONE.
  - Reads go to WAIT: POP addr=jsp-1 and jsp<=jsp-1; PEEK addr=jsp-1-ofs; LOAD addr=jframe+ofs; DUP addr=jsp-1; MCU read addr=m_addr.
- WAIT: lasts RAM_LAT cycles; on the last cycle capture ram_q into e_rdata or m_rdata. DUP goes to DUPWR; others go to DONE.
- DUPWR: addr=jsp, data=captured q, ram_wren=1; jsp<=jsp+1; go to DONE.
- DONE: e_done or m_ack=1 for one cycle; go to IDLE. Next grant possible in the following cycle.
- Latency, accept cycle to done (RAM_LAT=1):
  - write/SET*: done in cycle 2.
  - read: cycle 3.
  - DUP: cycle 4.
- Overflow: PUSH/DUP with jsp==2^AW-1 is not performed. Set err, jsp unchanged, no RAM write, skip straight from ISSUE to DONE; e_done still pulses.
- Underflow: POP/DUP with jsp==0, or PEEK with ofs>=jsp, gets the same treatment; e_rdata unchanged.
- Frame-relative and SETSP/SETFP arithmetic wraps modulo 2^AW with no check.
- Outside write cycles, ram_wren=0 and ram_addr/ram_wdata hold their last value.
- MCU accesses never modify jsp or jframe.

Test Plan:
- Reset, PUSH 0x1111, PUSH 0x2222, POP -> jsp 0→1→2→1; e_rdata=0x2222 in cycle 3 after POP accept; RAM word 1 holds 0x2222.
- SETFP 5, STORE ofs=2 data 0xBEEF, LOAD ofs=2 -> RAM[7]=0xBEEF; e_rdata=0xBEEF; jsp unchanged.
- jsp=3 holding RAM[2]=0x00AA, DUP -> RAM[3]=0x00AA, jsp=4, e_rdata=0x00AA, e_done in cycle 4 after accept; PEEK ofs=1 -> 0x00AA.
- jsp=0, POP -> err=1, jsp=0, no ram_wren, e_done pulses. SETSP 1023 (AW=10), PUSH -> err stays 1, jsp=1023. err_clr -> err=0.
- e_valid and m_req asserted together continuously for 4 grants -> grants alternate E,M,E,M starting with E after reset. m_rdata/e_rdata correct; only one RAM access in flight at a time.
- Assert sysreset_n low during WAIT of a POP -> immediately jsp=0, ram_wren=0, e_ready=1 after release, no e_done.
